// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flip-flop drive sequencer.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } sr_seq_state_t;

    localparam logic SR_CMD_SET   = 1'b1;
    localparam logic SR_CMD_RESET = 1'b0;

    localparam int SR_PHASE_W = 4;

    // A phase of N cycles runs while the counter steps down from N-1 to 0.
    function automatic logic [SR_PHASE_W-1:0] phase_load(input int cycles);
        return SR_PHASE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sr_drive_sequencer.sv
// Drives s/r/en of a gated SR flip-flop with setup / enable pulse / hold sequencing,
// and tracks the expected latch state and completed command count.
module sr_drive_sequencer
    import sr_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_set,
    output logic       req_ready,
    output logic       s,
    output logic       r,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic       exp_q,
    output logic       exp_valid,
    output logic [7:0] cmd_count
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("sr_drive_sequencer: SETUP_CYC must be in 1..15");
    end
    if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_bad_pulse
        $error("sr_drive_sequencer: PULSE_CYC must be in 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("sr_drive_sequencer: HOLD_CYC must be in 1..15");
    end

    sr_seq_state_t         state, state_n;
    logic [SR_PHASE_W-1:0] cnt, cnt_n;
    logic                  cmd, cmd_n;
    logic                  s_n, r_n, en_n;
    logic                  ready_n, busy_n, done_n;
    logic                  exp_q_n, exp_valid_n;
    logic [7:0]            cmd_count_n;

    // Every output is a flop so the flip-flop never sees a combinational glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd       <= SR_CMD_RESET;
            s         <= 1'b0;
            r         <= 1'b1;
            en        <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            exp_q     <= 1'b0;
            exp_valid <= 1'b0;
            cmd_count <= 8'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cmd       <= cmd_n;
            s         <= s_n;
            r         <= r_n;
            en        <= en_n;
            req_ready <= ready_n;
            busy      <= busy_n;
            done      <= done_n;
            exp_q     <= exp_q_n;
            exp_valid <= exp_valid_n;
            cmd_count <= cmd_count_n;
        end
    end

    // s/r are only reloaded on acceptance in IDLE, so they are frozen while en is high.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cmd_n       = cmd;
        s_n         = s;
        r_n         = r;
        en_n        = en;
        done_n      = 1'b0;
        exp_q_n     = exp_q;
        exp_valid_n = exp_valid;
        cmd_count_n = cmd_count;

        case (state)
            IDLE: begin
                en_n = 1'b0;
                if (req_valid && req_ready) begin
                    cmd_n   = req_set;
                    s_n     = (req_set == SR_CMD_SET);
                    r_n     = (req_set == SR_CMD_RESET);
                    cnt_n   = phase_load(SETUP_CYC);
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    en_n    = 1'b1;
                    cnt_n   = phase_load(PULSE_CYC);
                    state_n = PULSE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    en_n    = 1'b0;
                    cnt_n   = phase_load(HOLD_CYC);
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n     = IDLE;
                    done_n      = 1'b1;
                    exp_q_n     = cmd;
                    exp_valid_n = 1'b1;
                    cmd_count_n = cmd_count + 8'd1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
            end
        endcase

        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Randomized self-checking bench: two sequencers (1/2/1 and 3/1/2) against a
// cycles-since-acceptance reference model.
module tb_sr_drive_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req_valid;
    logic [1:0] req_set;
    logic [1:0] req_ready, s, r, en, busy, done, exp_q, exp_valid;
    logic [7:0] cmd_count [2];

    int setup_p [2] = '{1, 3};
    int pulse_p [2] = '{2, 1};
    int hold_p  [2] = '{1, 2};

    // Reference model: mk = cycles since acceptance (0 = idle).
    int mk [2];
    bit m_set [2], m_done [2], m_q [2], m_qv [2];
    int m_cnt [2];

    bit q0 [$];
    bit q1 [$];
    bit garbage;
    int pass_count;
    int check_count;

    sr_drive_sequencer #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_set(req_set[0]), .req_ready(req_ready[0]),
        .s(s[0]), .r(r[0]), .en(en[0]), .busy(busy[0]), .done(done[0]),
        .exp_q(exp_q[0]), .exp_valid(exp_valid[0]), .cmd_count(cmd_count[0])
    );

    sr_drive_sequencer #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_set(req_set[1]), .req_ready(req_ready[1]),
        .s(s[1]), .r(r[1]), .en(en[1]), .busy(busy[1]), .done(done[1]),
        .exp_q(exp_q[1]), .exp_valid(exp_valid[1]), .cmd_count(cmd_count[1])
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_prot
        assert property (@(posedge clk) disable iff (rst) !(en[g] && (s[g] == r[g])));
        assert property (@(posedge clk) disable iff (rst)
            (en[g] && $past(en[g])) |-> (s[g] == $past(s[g]) && r[g] == $past(r[g])));
        assert property (@(posedge clk) disable iff (rst) !busy[g] |-> !en[g]);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        check_count++;
        if (obs === expv) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    endtask

    function automatic int qSize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic bit qFront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qPop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qPush(input int d, input bit v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mk[d] = 0; m_set[d] = 0; m_done[d] = 0;
            m_q[d] = 0; m_qv[d] = 0; m_cnt[d] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic driveInputs();
        for (int d = 0; d < 2; d++) begin
            if (mk[d] != 0 && garbage) begin
                req_valid[d] = 1'($urandom);
                req_set[d]   = 1'($urandom);
            end else begin
                req_valid[d] = (qSize(d) != 0);
                req_set[d]   = (qSize(d) != 0) ? qFront(d) : 1'($urandom);
            end
        end
    endtask

    task automatic modelAdvance();
        for (int d = 0; d < 2; d++) begin
            int len;
            len = setup_p[d] + pulse_p[d] + hold_p[d];
            m_done[d] = 0;
            if (mk[d] == 0) begin
                if (req_valid[d]) begin
                    mk[d] = 1;
                    m_set[d] = req_set[d];
                    qPop(d);
                end
            end else if (mk[d] == len) begin
                mk[d] = 0;
                m_done[d] = 1;
                m_q[d] = m_set[d];
                m_qv[d] = 1;
                m_cnt[d] = (m_cnt[d] + 1) % 256;
            end else begin
                mk[d]++;
            end
        end
    endtask

    task automatic checkAll();
        for (int d = 0; d < 2; d++) begin
            bit en_e;
            en_e = (mk[d] > setup_p[d]) && (mk[d] <= setup_p[d] + pulse_p[d]);
            checkOutput($sformatf("d%0d_en", d), 32'(en[d]), 32'(en_e));
            checkOutput($sformatf("d%0d_s", d), 32'(s[d]), 32'(m_set[d]));
            checkOutput($sformatf("d%0d_r", d), 32'(r[d]), 32'(!m_set[d]));
            checkOutput($sformatf("d%0d_ready", d), 32'(req_ready[d]), 32'(mk[d] == 0));
            checkOutput($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(mk[d] != 0));
            checkOutput($sformatf("d%0d_done", d), 32'(done[d]), 32'(m_done[d]));
            checkOutput($sformatf("d%0d_exp_q", d), 32'(exp_q[d]), 32'(m_q[d]));
            checkOutput($sformatf("d%0d_exp_valid", d), 32'(exp_valid[d]), 32'(m_qv[d]));
            checkOutput($sformatf("d%0d_count", d), 32'(cmd_count[d]), 32'(m_cnt[d]));
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            driveInputs();
            @(posedge clk);
            modelAdvance();
            @(negedge clk);
            checkAll();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        checkAll();
        rst = 1'b0;
    endtask

    initial begin
        int lat0, lat1, guard;
        pass_count  = 0;
        check_count = 0;
        garbage     = 0;
        req_valid   = '0;
        req_set     = '0;
        modelReset();

        #1 doReset();

        // Single set: done lands 5 cycles (defaults) / 7 cycles (3/1/2) after acceptance.
        lat0 = 0;
        lat1 = 0;
        qPush(0, 1'b1);
        qPush(1, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1);
            if (done[0] && lat0 == 0) lat0 = i;
            if (done[1] && lat1 == 0) lat1 = i;
        end
        checkOutput("latency_default", 32'(lat0), 32'd5);
        checkOutput("latency_312", 32'(lat1), 32'd7);

        // Back-to-back set then reset, second request held while busy.
        qPush(0, 1'b1);
        qPush(0, 1'b0);
        qPush(1, 1'b0);
        qPush(1, 1'b1);
        applyStimulus(18);

        // Asynchronous reset in the middle of the enable pulse.
        qPush(0, 1'b1);
        applyStimulus(2);
        checkOutput("pre_rst_en", 32'(en[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_en", 32'(en[0]), 32'd0);
        checkOutput("async_s", 32'(s[0]), 32'd0);
        checkOutput("async_r", 32'(r[0]), 32'd1);
        checkOutput("async_done", 32'(done[0]), 32'd0);
        checkOutput("async_exp_valid", 32'(exp_valid[0]), 32'd0);
        checkOutput("async_count", 32'(cmd_count[0]), 32'd0);
        checkOutput("async_ready", 32'(req_ready[0]), 32'd1);
        doReset();
        qPush(0, 1'b0);
        qPush(1, 1'b1);
        applyStimulus(10);

        // Random traffic, with garbage on req_valid/req_set while busy.
        garbage = 1;
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++)
                if (qSize(d) == 0 && ($urandom % 3) == 0) qPush(d, 1'($urandom));
            applyStimulus(1);
        end
        garbage = 0;

        // 256 consecutive sets from a clean reset wrap the counter to 0.
        doReset();
        for (int i = 0; i < 256; i++) qPush(0, 1'b1);
        guard = 0;
        while ((q0.size() != 0 || mk[0] != 0) && guard < 1400) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput("wrap_timeout", 32'(guard < 1400), 32'd1);
        checkOutput("wrap_count", 32'(cmd_count[0]), 32'd0);
        checkOutput("wrap_exp_q", 32'(exp_q[0]), 32'd1);
        checkOutput("wrap_exp_valid", 32'(exp_valid[0]), 32'd1);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
